// File: rtl/riscv_pkg.sv
// Shared RV32M multiply/divide definitions: funct3 codes, FSM state type and
// the operand-signedness helpers used by the MDU and its bench.
package riscv_pkg;

  localparam int DATA_SIZE_DEF = 32;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/mdu_iterative_if.sv
// Request/response bundle between the core's operand muxes and the MDU.
interface mdu_iterative_if
  import riscv_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF
);
  logic                 start;
  logic [2:0]           op;
  logic [DATA_SIZE-1:0] rs1_data;
  logic [DATA_SIZE-1:0] rs2_data;
  logic                 busy;
  logic                 done;
  logic [DATA_SIZE-1:0] result;

  modport master (output start, op, rs1_data, rs2_data, input busy, done, result);
  modport slave  (input start, op, rs1_data, rs2_data, output busy, done, result);
endinterface

// File: rtl/mdu_div_core.sv
// Restoring-division datapath on unsigned magnitudes: one quotient bit per step.
module mdu_div_core #(
  parameter int DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 load,
  input  logic                 step,
  input  logic [DATA_SIZE-1:0] dividend,
  input  logic [DATA_SIZE-1:0] divisor,
  output logic [DATA_SIZE-1:0] quo_nxt,
  output logic [DATA_SIZE-1:0] rem_nxt
);
  localparam int N = DATA_SIZE;

  logic [N-1:0] quo_q, quo_d;
  logic [N-1:0] rem_q, rem_d;
  logic [N-1:0] dvs_q, dvs_d;
  logic [N:0]   shifted;
  logic [N:0]   diff;

  // quo_q doubles as the dividend shift register: its MSB feeds the remainder.
  always_comb begin
    shifted = {rem_q, quo_q[N-1]};
    diff    = shifted - {1'b0, dvs_q};
    quo_nxt = {quo_q[N-2:0], ~diff[N]};
    rem_nxt = diff[N] ? shifted[N-1:0] : diff[N-1:0];
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    if (load) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
    end else if (step) begin
      quo_d = quo_nxt;
      rem_d = rem_nxt;
    end
  end

  always_ff @(posedge clk) begin
    quo_q <= quo_d;
    rem_q <= rem_d;
    dvs_q <= dvs_d;
  end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Optional MDU_FAST_MUL_EN: single-cycle combinational multiply path.
module mdu_iterative
  import riscv_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF
) (
  input logic              clk,
  input logic              rst,
  mdu_iterative_if.slave   bus
);
  localparam int N  = DATA_SIZE;
  localparam int CW = $clog2(DATA_SIZE);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_SIZE - 1);

  mdu_state_t     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   result_q, result_d;
  logic [2:0]     op_q, op_d;
  logic [N-1:0]   a_q, a_d;
  logic           div0_q, div0_d;
  logic           a_neg_q, a_neg_d;
  logic           b_neg_q, b_neg_d;
  logic [2*N-1:0] prod_q, prod_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;

  logic           accept, last;
  logic           a_sgn_in, b_sgn_in, a_neg_in, b_neg_in;
  logic [N-1:0]   a_mag_in, b_mag_in;
  logic [2*N-1:0] prod_nxt;
  logic           div_load, div_step;
  logic [N-1:0]   div_quo_nxt, div_rem_nxt, quo_fix, rem_fix;
`ifdef MDU_FAST_MUL_EN
  logic signed [2*N-1:0] fast_a, fast_b, fast_prod;
`endif

  mdu_div_core #(.DATA_SIZE(N)) u_div (
    .clk      (clk),
    .load     (div_load),
    .step     (div_step),
    .dividend (a_mag_in),
    .divisor  (b_mag_in),
    .quo_nxt  (div_quo_nxt),
    .rem_nxt  (div_rem_nxt)
  );

  always_comb begin
    accept   = bus.start && (state_q != CALC);
    last     = (state_q == CALC) && (cnt_q == CNT_LAST);
    a_sgn_in = op_a_signed(bus.op);
    b_sgn_in = op_b_signed(bus.op);
    a_neg_in = a_sgn_in && bus.rs1_data[N-1];
    b_neg_in = b_sgn_in && bus.rs2_data[N-1];
    a_mag_in = a_neg_in ? -bus.rs1_data : bus.rs1_data;
    b_mag_in = b_neg_in ? -bus.rs2_data : bus.rs2_data;
    div_load = accept && bus.op[2];
    div_step = (state_q == CALC) && op_q[2];

    // The multiplier MSB carries negative weight when operand B is signed.
    prod_nxt = prod_q;
    if (mplier_q[0]) prod_nxt = (last && b_neg_q) ? prod_q - mcand_q : prod_q + mcand_q;

    quo_fix = (a_neg_q ^ b_neg_q) ? -div_quo_nxt : div_quo_nxt;
    rem_fix = a_neg_q ? -div_rem_nxt : div_rem_nxt;

`ifdef MDU_FAST_MUL_EN
    fast_a    = signed'({{N{a_sgn_in & bus.rs1_data[N-1]}}, bus.rs1_data});
    fast_b    = signed'({{N{b_sgn_in & bus.rs2_data[N-1]}}, bus.rs2_data});
    fast_prod = fast_a * fast_b;
`endif

    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    op_d     = op_q;
    a_d      = a_q;
    div0_d   = div0_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;

    if (state_q == CALC) begin
      cnt_d    = cnt_q + CW'(1);
      prod_d   = prod_nxt;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (last) begin
        state_d = DONE;
        cnt_d   = '0;
        if (!op_q[2])    result_d = (op_q == MDU_MUL) ? prod_nxt[N-1:0] : prod_nxt[2*N-1:N];
        else if (div0_q) result_d = op_q[1] ? a_q : '1;
        else             result_d = op_q[1] ? rem_fix : quo_fix;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end

    // Accept never coincides with CALC, so it cleanly overrides the DONE->IDLE step.
    if (accept) begin
      state_d  = CALC;
      cnt_d    = '0;
      op_d     = bus.op;
      a_d      = bus.rs1_data;
      div0_d   = (bus.rs2_data == '0);
      a_neg_d  = a_neg_in;
      b_neg_d  = b_neg_in;
      prod_d   = '0;
      mcand_d  = {{N{a_sgn_in & bus.rs1_data[N-1]}}, bus.rs1_data};
      mplier_d = bus.rs2_data;
`ifdef MDU_FAST_MUL_EN
      if (!bus.op[2]) begin
        state_d  = DONE;
        result_d = (bus.op == MDU_MUL) ? fast_prod[N-1:0] : fast_prod[2*N-1:N];
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q     <= op_d;
    a_q      <= a_d;
    div0_q   <= div0_d;
    a_neg_q  <= a_neg_d;
    b_neg_q  <= b_neg_d;
    prod_q   <= prod_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end

  assign bus.busy   = (state_q == CALC);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed table, random ops against an
// arithmetic reference model, and multi-cycle handshake/reset sequences.
module tb_mdu_iterative;
  import riscv_pkg::*;

  localparam int N = 32;
`ifdef MDU_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mdu_iterative_if #(.DATA_SIZE(N)) bus ();
  mdu_iterative #(.DATA_SIZE(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MDU_MUL:    begin p = ua * ub; return p[31:0]; end
      MDU_MULH:   begin p = sa * sb; return p[63:32]; end
      MDU_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      MDU_MULHU:  begin p = ua * ub; return p[63:32]; end
      MDU_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(signed'(a) / signed'(b));
      end
      MDU_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(signed'(a) % signed'(b));
      end
      MDU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default:  return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op);
    return (FAST && !op[2]) ? 1 : N + 1;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start    = 1'b1;
    bus.op       = op;
    bus.rs1_data = a;
    bus.rs2_data = b;
    @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.op       = 3'($urandom);
    bus.rs1_data = $urandom;
    bus.rs2_data = $urandom;
  endtask

  task automatic wait_done(input bit exp_busy, output int lat, output bit busy_ok);
    lat     = 1;
    busy_ok = 1'b1;
    while (!bus.done && lat <= 40) begin
      if (bus.busy !== exp_busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (bus.busy !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int lat;
    bit bok;
    issue(op, a, b);
    wait_done(exp_lat(op) != 1, lat, bok);
    check({name, " result"}, bus.result, exp);
    check({name, " latency"}, 32'(lat), 32'(exp_lat(op)));
    check({name, " busy"}, 32'(bok), 32'd1);
    @(negedge clk);
    check({name, " done pulse"}, 32'(bus.done), 32'd0);
    check({name, " held"}, bus.result, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int pulses;
    bit bok;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    bus.start = 1'b0; bus.op = '0; bus.rs1_data = '0; bus.rs2_data = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset result", bus.result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    vecs.push_back('{MDU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB});
    vecs.push_back('{MDU_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000});
    vecs.push_back('{MDU_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF});
    vecs.push_back('{MDU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE});
    vecs.push_back('{MDU_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD});
    vecs.push_back('{MDU_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF});
    vecs.push_back('{MDU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000});
    vecs.push_back('{MDU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0});
    vecs.push_back('{MDU_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF});
    vecs.push_back('{MDU_REMU,   32'd5,          32'd0,         32'd5});
    vecs.push_back('{MDU_DIV,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF});
    vecs.push_back('{MDU_REM,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9});
    vecs.push_back('{MDU_DIVU,   32'd100,        32'd7,         32'd14});
    vecs.push_back('{MDU_MUL,    32'd3,          32'd4,         32'd12});

    for (int i = 0; i < vecs.size(); i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick_operand();
      rb  = pick_operand();
      run_op($sformatf("rand%0d op%0d %h %h", i, rop, ra, rb), rop, ra, rb, ref_mdu(rop, ra, rb));
    end

    // Start pulse while busy must be ignored; then back-to-back issue from DONE.
    bus.start = 1'b1; bus.op = MDU_DIVU; bus.rs1_data = 32'd100; bus.rs2_data = 32'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat <= 40) begin
      if (lat == 5) begin
        bus.start = 1'b1; bus.op = MDU_MUL; bus.rs1_data = 32'd3; bus.rs2_data = 32'd4;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    check("ignore start result", bus.result, 32'd14);
    check("ignore start latency", 32'(lat), 32'(N + 1));
    issue(MDU_REMU, 32'd100, 32'd7);
    wait_done(1'b1, lat, bok);
    check("b2b result", bus.result, 32'd2);
    check("b2b latency", 32'(lat), 32'(N + 1));
    check("b2b busy", 32'(bok), 32'd1);
    @(negedge clk);

    // Reset in the middle of a divide aborts it without a done pulse.
    issue(MDU_DIV, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort result", bus.result, 32'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check("abort no done", 32'(pulses), 32'd0);
    check("abort result kept", bus.result, 32'd0);
    run_op("post-abort mul", MDU_MUL, 32'd3, 32'd4, 32'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
